id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus operand forwarding and load-use hazard detection for the 5-stage RV32 core.
//  Latches decoded fields on clk. Drives the ALU's dataA/dataB/func/aluOp from the registered fields,
//  with EX/MEM and MEM/WB results forwarded in. Requests a one-cycle decode stall on a load-use dependency.
// PARAMETERS
//  width    32  datapath width (pc, operands, imm, results)
//  REGBITS  5   register-index width
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        async active-high reset
//  mem_stall      in   1        downstream memory busy; hold all state
//  flush          in   1        taken branch/jump; squash incoming instruction
//  id_valid       in   1        decode slot holds a real instruction
//  id_pc          in   width    pc of decode instruction
//  id_rs1,id_rs2  in   REGBITS  source indices
//  id_rs1_data    in   width    regfile read port 1
//  id_rs2_data    in   width    regfile read port 2
//  id_imm         in   width    sign-extended immediate
//  id_rd          in   REGBITS  destination index
//  id_func        in   4        {funct7[5],funct3}
//  id_aluOp       in   3        ALU op class
//  id_srcA_pc     in   1        dataA = pc
//  id_srcB_imm    in   1        dataB = imm
//  id_ctrl        in   4        {regWrite,memRead,memWrite,branch}
//  exmem_rd       in   REGBITS  EX/MEM destination
//  exmem_regWrite in   1        EX/MEM writes rd
//  exmem_result   in   width    EX/MEM ALU result
//  memwb_rd       in   REGBITS  MEM/WB destination
//  memwb_regWrite in   1        MEM/WB writes rd
//  memwb_result   in   width    MEM/WB writeback value
//  hazard_stall   out  1        load-use: hold PC and IF/ID this cycle
//  ex_valid       out  1        registered valid
//  ex_pc          out  width    registered pc
//  ex_rd          out  REGBITS  registered rd
//  ex_ctrl        out  4        registered control; forced 0 when !ex_valid
//  alu_dataA      out  width    ALU operand A (forwarded)
//  alu_dataB      out  width    ALU operand B (forwarded or imm)
//  alu_func       out  4        registered func
//  alu_aluOp      out  3        registered aluOp
//  store_data     out  width    forwarded rs2 for stores
// BEHAVIOUR
//  - Reset (async): every register cleared, so all outputs are 0 and ex_valid=0 (bubble).
//  - Register update priority each clk:
//    rst > mem_stall (hold) > flush (bubble) > hazard_stall (bubble) > load id_* (ex_valid=id_valid).
//  - Bubble: ex_valid=0; ex_ctrl=0; ex_rd=0; other fields don't-care, but implementation zeroes them.
//  - hazard_stall is combinational: ex_valid & ex_ctrl.memRead & ex_rd!=0 & id_valid &
//    (ex_rd==id_rs1 | ex_rd==id_rs2). Asserted even during mem_stall.
//  - Forwarding (combinational, per source, on registered rs1/rs2):
//    1. exmem_regWrite & exmem_rd!=0 & exmem_rd==rs  -> exmem_result (wins over MEM/WB).
//    2. else memwb_regWrite & memwb_rd!=0 & memwb_rd==rs -> memwb_result.
//    3. else the registered regfile data.
//    Index x0 is never forwarded.
//  - Operand muxes:
//    alu_dataA = srcA_pc ? ex_pc : fwdA.
//    alu_dataB = srcB_imm ? imm : fwdB.
//    store_data = fwdB always.
//  - Latency: id_* to alu_* is one clock. exmem/memwb to alu_dataA/B is zero-cycle combinational.
//  - flush and hazard_stall in the same cycle: bubble. hazard_stall is still asserted; upstream drops it on flush.
// STRUCTURE
//  - riscv_pkg: aluOp encodings (ADD=000, SUB=001, FUNCT=010), ctrl bit positions, REGBITS, fwd-select enum {FWD_RF,FWD_EXMEM,FWD_MEMWB}.
//  - Sub-module fwd_unit: one instance per source operand; inputs rs, regfile data and both writeback ports; output is the forwarded value.
// TESTING
//  - Reset mid-operation with ex_valid=1 -> all outputs 0 in the same cycle, without waiting for clk.
//  - add x3,x1,x2 with rs1_data=5, rs2_data=7 -> next cycle alu_dataA=5, alu_dataB=7, aluOp=010.
//  - Forwarding priority: rs1=x4; exmem_rd=4 (0xAA, regWrite=1) and memwb_rd=4 (0xBB) -> alu_dataA=0xAA.
//    Drop exmem_regWrite -> 0xBB. Any rd=0 match -> regfile value.
//  - Load-use: ex holds lw x5 (memRead=1); id_rs2=5, id_valid=1 -> hazard_stall=1, next ex_valid=0.
//    Same case with id_rs2=0 and ex_rd=0 -> hazard_stall=0.
//  - mem_stall=1 for 3 cycles while id_* changes -> ex_* and alu_func hold. flush=1 at the same time -> still hold.
//  - flush=1 with a valid sw -> next ex_valid=0 and ex_ctrl=0. srcB_imm with imm=-4 -> alu_dataB=0xFFFFFFFC, store_data=fwdB.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RV32 pipeline (ALU op classes, control bits, forwarding selects).
package riscv_pkg;
  localparam int REGBITS = 5;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_BRANCH = 0;
  typedef enum logic [1:0] {FWD_RF, FWD_EXMEM, FWD_MEMWB} fwd_sel_e;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: picks the freshest value of one source register from EX/MEM, MEM/WB or the regfile.
module fwd_unit
  import riscv_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [REGBITS-1:0] rs_i,
  input  logic [width-1:0]   rf_data_i,
  input  logic [REGBITS-1:0] exmem_rd_i,
  input  logic               exmem_regWrite_i,
  input  logic [width-1:0]   exmem_result_i,
  input  logic [REGBITS-1:0] memwb_rd_i,
  input  logic               memwb_regWrite_i,
  input  logic [width-1:0]   memwb_result_i,
  output logic [width-1:0]   data_o
);
  fwd_sel_e sel;
  always_comb begin
    sel = (exmem_regWrite_i && exmem_rd_i != '0 && exmem_rd_i == rs_i) ? FWD_EXMEM :
          (memwb_regWrite_i && memwb_rd_i != '0 && memwb_rd_i == rs_i) ? FWD_MEMWB : FWD_RF;
    data_o = sel == FWD_EXMEM ? exmem_result_i :
             sel == FWD_MEMWB ? memwb_result_i : rf_data_i;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use hazard detection.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int width = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [width-1:0]   id_pc,
  input  logic [REGBITS-1:0] id_rs1,
  input  logic [REGBITS-1:0] id_rs2,
  input  logic [width-1:0]   id_rs1_data,
  input  logic [width-1:0]   id_rs2_data,
  input  logic [width-1:0]   id_imm,
  input  logic [REGBITS-1:0] id_rd,
  input  logic [3:0]         id_func,
  input  logic [2:0]         id_aluOp,
  input  logic               id_srcA_pc,
  input  logic               id_srcB_imm,
  input  logic [3:0]         id_ctrl,
  input  logic [REGBITS-1:0] exmem_rd,
  input  logic               exmem_regWrite,
  input  logic [width-1:0]   exmem_result,
  input  logic [REGBITS-1:0] memwb_rd,
  input  logic               memwb_regWrite,
  input  logic [width-1:0]   memwb_result,
  output logic               hazard_stall,
  output logic               ex_valid,
  output logic [width-1:0]   ex_pc,
  output logic [REGBITS-1:0] ex_rd,
  output logic [3:0]         ex_ctrl,
  output logic [width-1:0]   alu_dataA,
  output logic [width-1:0]   alu_dataB,
  output logic [3:0]         alu_func,
  output logic [2:0]         alu_aluOp,
  output logic [width-1:0]   store_data
);
  localparam int BW = 4 * width + 3 * REGBITS + 14;
  logic [BW-1:0] ex_q, ex_d;
  logic [REGBITS-1:0] rs1_q, rs2_q;
  logic [width-1:0] rs1_data_q, rs2_data_q, imm_q, fwd_a, fwd_b;
  logic [3:0] ctrl_q;
  logic srca_q, srcb_q;
  // The whole stage is one flat register; a bubble is simply all zeroes.
  always_comb
    ex_d = mem_stall ? ex_q :
           (flush || hazard_stall || !id_valid) ? '0 :
           {id_valid, id_pc, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_rd,
            id_func, id_aluOp, id_srcA_pc, id_srcB_imm, id_ctrl};
  always_ff @(posedge clk or posedge rst)
    if (rst) ex_q <= '0;
    else ex_q <= ex_d;
  assign {ex_valid, ex_pc, rs1_q, rs2_q, rs1_data_q, rs2_data_q, imm_q, ex_rd,
          alu_func, alu_aluOp, srca_q, srcb_q, ctrl_q} = ex_q;
  assign ex_ctrl = ex_valid ? ctrl_q : 4'b0;
  assign hazard_stall = ex_valid && ex_ctrl[CTRL_MEMREAD] && ex_rd != '0 && id_valid &&
                        (ex_rd == id_rs1 || ex_rd == id_rs2);
  fwd_unit #(.width(width)) u_fwd_a (
    .rs_i(rs1_q), .rf_data_i(rs1_data_q),
    .exmem_rd_i(exmem_rd), .exmem_regWrite_i(exmem_regWrite), .exmem_result_i(exmem_result),
    .memwb_rd_i(memwb_rd), .memwb_regWrite_i(memwb_regWrite), .memwb_result_i(memwb_result),
    .data_o(fwd_a)
  );
  fwd_unit #(.width(width)) u_fwd_b (
    .rs_i(rs2_q), .rf_data_i(rs2_data_q),
    .exmem_rd_i(exmem_rd), .exmem_regWrite_i(exmem_regWrite), .exmem_result_i(exmem_result),
    .memwb_rd_i(memwb_rd), .memwb_regWrite_i(memwb_regWrite), .memwb_result_i(memwb_result),
    .data_o(fwd_b)
  );
  assign alu_dataA = srca_q ? ex_pc : fwd_a;
  assign alu_dataB = srcb_q ? imm_q : fwd_b;
  assign store_data = fwd_b;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed, self-checking bench for the ID/EX stage.
module tb_id_ex_stage;
  logic clk = 0, rst = 1, mem_stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result;
  logic [4:0] id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
  logic [3:0] id_func, id_ctrl;
  logic [2:0] id_aluOp;
  logic id_srcA_pc, id_srcB_imm, exmem_regWrite, memwb_regWrite;
  logic hazard_stall, ex_valid;
  logic [31:0] ex_pc, alu_dataA, alu_dataB, store_data;
  logic [4:0] ex_rd;
  logic [3:0] ex_ctrl, alu_func;
  logic [2:0] alu_aluOp;
  int n_cmp = 0, n_err = 0;

  id_ex_stage #(.width(32)) dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rd(id_rd), .id_func(id_func),
    .id_aluOp(id_aluOp), .id_srcA_pc(id_srcA_pc), .id_srcB_imm(id_srcB_imm), .id_ctrl(id_ctrl),
    .exmem_rd(exmem_rd), .exmem_regWrite(exmem_regWrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite), .memwb_result(memwb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_func(alu_func),
    .alu_aluOp(alu_aluOp), .store_data(store_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {mem_stall, flush, id_valid, id_srcA_pc, id_srcB_imm, exmem_regWrite, memwb_regWrite} = '0;
    {id_pc, id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result} = '0;
    {id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd} = '0;
    {id_func, id_ctrl, id_aluOp} = '0;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                          input logic [31:0] d1, d2, imm, input logic [3:0] func,
                          input logic [2:0] op, input logic sa, sb, input logic [3:0] ctrl);
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_func = func;
    id_aluOp = op; id_srcA_pc = sa; id_srcB_imm = sb; id_ctrl = ctrl;
  endtask

  task automatic bubble();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    #3;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", ex_valid); end
    n_cmp++; if ({ex_pc, alu_dataA, alu_dataB, store_data} !== 128'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", {ex_pc, alu_dataA, alu_dataB, store_data}); end
    n_cmp++; if ({ex_rd, ex_ctrl, alu_func, alu_aluOp, hazard_stall} !== 17'h0) begin n_err++; $display("FAIL reset_ctrl got %h exp 0", {ex_rd, ex_ctrl, alu_func, alu_aluOp, hazard_stall}); end
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic test_add();
    bubble();
    drive_id(32'h40, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 4'h0, 3'b010, 1'b0, 1'b0, 4'b1000);
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (alu_dataA !== 32'd5) begin n_err++; $display("FAIL add_dataA got %h exp 5", alu_dataA); end
    n_cmp++; if (alu_dataB !== 32'd7) begin n_err++; $display("FAIL add_dataB got %h exp 7", alu_dataB); end
    n_cmp++; if ({ex_valid, alu_aluOp, ex_rd, ex_ctrl} !== {1'b1, 3'b010, 5'd3, 4'b1000}) begin n_err++; $display("FAIL add_fields got %h exp %h", {ex_valid, alu_aluOp, ex_rd, ex_ctrl}, {1'b1, 3'b010, 5'd3, 4'b1000}); end
    n_cmp++; if (ex_pc !== 32'h40) begin n_err++; $display("FAIL add_pc got %h exp 40", ex_pc); end
  endtask

  task automatic test_reset_midop();
    #2;
    rst = 1;
    #1;
    n_cmp++; if ({ex_valid, ex_rd, ex_ctrl, alu_aluOp} !== 13'h0) begin n_err++; $display("FAIL midop_reset_ctrl got %h exp 0", {ex_valid, ex_rd, ex_ctrl, alu_aluOp}); end
    n_cmp++; if ({ex_pc, alu_dataA, alu_dataB} !== 96'h0) begin n_err++; $display("FAIL midop_reset_data got %h exp 0", {ex_pc, alu_dataA, alu_dataB}); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_forwarding();
    bubble();
    drive_id(32'h80, 5'd4, 5'd6, 5'd7, 32'h11, 32'h22, 32'h0, 4'h0, 3'b000, 1'b0, 1'b0, 4'b1000);
    tick();
    clear_inputs();
    exmem_rd = 4; exmem_regWrite = 1; exmem_result = 32'hAA;
    memwb_rd = 4; memwb_regWrite = 1; memwb_result = 32'hBB;
    #1;
    n_cmp++; if (alu_dataA !== 32'hAA) begin n_err++; $display("FAIL fwd_exmem_prio got %h exp aa", alu_dataA); end
    n_cmp++; if (alu_dataB !== 32'h22) begin n_err++; $display("FAIL fwd_b_untouched got %h exp 22", alu_dataB); end
    exmem_regWrite = 0;
    #1;
    n_cmp++; if (alu_dataA !== 32'hBB) begin n_err++; $display("FAIL fwd_memwb got %h exp bb", alu_dataA); end
    memwb_rd = 6;
    #1;
    n_cmp++; if ({alu_dataA, alu_dataB, store_data} !== {32'h11, 32'hBB, 32'hBB}) begin n_err++; $display("FAIL fwd_rs2_memwb got %h exp %h", {alu_dataA, alu_dataB, store_data}, {32'h11, 32'hBB, 32'hBB}); end
    clear_inputs();
    drive_id(32'h84, 5'd0, 5'd0, 5'd7, 32'h11, 32'h22, 32'h0, 4'h0, 3'b000, 1'b0, 1'b0, 4'b1000);
    tick();
    clear_inputs();
    exmem_rd = 0; exmem_regWrite = 1; exmem_result = 32'hAA;
    memwb_rd = 0; memwb_regWrite = 1; memwb_result = 32'hBB;
    #1;
    n_cmp++; if ({alu_dataA, alu_dataB} !== {32'h11, 32'h22}) begin n_err++; $display("FAIL fwd_x0 got %h exp %h", {alu_dataA, alu_dataB}, {32'h11, 32'h22}); end
  endtask

  task automatic test_load_use();
    bubble();
    drive_id(32'hC0, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h8, 4'h0, 3'b000, 1'b0, 1'b1, 4'b1100);
    tick();
    drive_id(32'hC4, 5'd1, 5'd5, 5'd9, 32'h0, 32'h0, 32'h0, 4'h0, 3'b010, 1'b0, 1'b0, 4'b1000);
    #1;
    n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL load_use_stall got %0b exp 1", hazard_stall); end
    tick();
    n_cmp++; if ({ex_valid, ex_ctrl, ex_rd} !== 10'h0) begin n_err++; $display("FAIL load_use_bubble got %h exp 0", {ex_valid, ex_ctrl, ex_rd}); end
    drive_id(32'hC8, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 4'h0, 3'b000, 1'b0, 1'b1, 4'b1100);
    tick();
    id_rs1 = 3; id_rs2 = 0;
    #1;
    n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL load_use_x0 got %0b exp 0", hazard_stall); end
  endtask

  task automatic test_mem_stall();
    bubble();
    drive_id(32'h100, 5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 32'h0, 4'h5, 3'b001, 1'b0, 1'b0, 4'b1100);
    tick();
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_id(32'h200 + i, 5'd6, 5'd2, 5'd8, 32'h0, 32'h0, 32'h0, 4'h9, 3'b010, 1'b0, 1'b0, 4'b1000);
      #1;
      n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL stall_hazard_during_mem_stall got %0b exp 1", hazard_stall); end
      tick();
      n_cmp++; if ({ex_valid, ex_pc, ex_rd, alu_func, alu_aluOp} !== {1'b1, 32'h100, 5'd6, 4'h5, 3'b001}) begin n_err++; $display("FAIL mem_stall_hold got %h exp %h", {ex_valid, ex_pc, ex_rd, alu_func, alu_aluOp}, {1'b1, 32'h100, 5'd6, 4'h5, 3'b001}); end
    end
    flush = 1;
    tick();
    n_cmp++; if ({ex_valid, ex_pc, ex_ctrl, alu_func} !== {1'b1, 32'h100, 4'b1100, 4'h5}) begin n_err++; $display("FAIL mem_stall_over_flush got %h exp %h", {ex_valid, ex_pc, ex_ctrl, alu_func}, {1'b1, 32'h100, 4'b1100, 4'h5}); end
    clear_inputs();
  endtask

  task automatic test_flush();
    bubble();
    drive_id(32'h300, 5'd1, 5'd2, 5'd0, 32'h10, 32'h33, 32'hFFFFFFFC, 4'h2, 3'b000, 1'b1, 1'b1, 4'b0010);
    flush = 1;
    tick();
    n_cmp++; if ({ex_valid, ex_ctrl} !== 5'h0) begin n_err++; $display("FAIL flush_bubble got %h exp 0", {ex_valid, ex_ctrl}); end
    flush = 0;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if ({ex_valid, ex_ctrl} !== 5'b10010) begin n_err++; $display("FAIL sw_fields got %b exp 10010", {ex_valid, ex_ctrl}); end
    n_cmp++; if ({alu_dataA, alu_dataB, store_data} !== {32'h300, 32'hFFFFFFFC, 32'h33}) begin n_err++; $display("FAIL sw_operands got %h exp %h", {alu_dataA, alu_dataB, store_data}, {32'h300, 32'hFFFFFFFC, 32'h33}); end
    memwb_rd = 2; memwb_regWrite = 1; memwb_result = 32'h44;
    #1;
    n_cmp++; if ({alu_dataB, store_data} !== {32'hFFFFFFFC, 32'h44}) begin n_err++; $display("FAIL sw_store_fwd got %h exp %h", {alu_dataB, store_data}, {32'hFFFFFFFC, 32'h44}); end
  endtask

  task automatic test_flush_hazard();
    bubble();
    drive_id(32'h400, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b0, 1'b1, 4'b1100);
    tick();
    drive_id(32'h404, 5'd5, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b0, 1'b0, 4'b1000);
    flush = 1;
    #1;
    n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL flush_hazard_stall got %0b exp 1", hazard_stall); end
    tick();
    n_cmp++; if ({ex_valid, ex_rd, ex_ctrl} !== 10'h0) begin n_err++; $display("FAIL flush_hazard_bubble got %h exp 0", {ex_valid, ex_rd, ex_ctrl}); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_add();
    test_reset_midop();
    test_forwarding();
    test_load_use();
    test_mem_stall();
    test_flush();
    test_flush_hazard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
